// File: rtl/ui_pkg.sv
// Shared UI input-path types and default cycle counts for a 100 MHz clock.
package ui_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        ARM_HIGH = 2'd1,
        HIGH     = 2'd2,
        ARM_LOW  = 2'd3
    } debounce_state_t;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 32'd1_000_000;
    localparam int unsigned DEFAULT_LONG_CYCLES     = 32'd100_000_000;

endpackage

// File: rtl/debouncer_if.sv
// Level and event bundle between the synchronizer/debouncer and the UI control logic.
interface debouncer_if;

    logic s_in;
    logic clean_out;
    logic rise_out;
    logic fall_out;
    logic long_out;

    modport master (
        output s_in,
        input  clean_out,
        input  rise_out,
        input  fall_out,
        input  long_out
    );

    modport slave (
        input  s_in,
        output clean_out,
        output rise_out,
        output fall_out,
        output long_out
    );

endinterface

// File: rtl/debouncer.sv
// Debounces an already-synchronized level into a clean level, edge pulses and a one-shot long-press pulse.
module debouncer
    import ui_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    debouncer_if.slave  dbif
);

    localparam int unsigned       DB_W      = $clog2(DEBOUNCE_CYCLES + 32'd1);
    localparam int unsigned       HOLD_W    = $clog2(LONG_CYCLES + 32'd1);
    localparam logic [DB_W-1:0]   DB_ZERO   = {DB_W{1'b0}};
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(32'd1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(32'd1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 32'd1);
    localparam logic              DB_SINGLE = (DEBOUNCE_CYCLES == 32'd1);

    debounce_state_t   state_r, state_nxt_s;
    logic [DB_W-1:0]   db_cnt_r, db_cnt_nxt_s;
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_nxt_s;
    logic              clean_r, rise_r, fall_r, long_r;
    logic              clean_nxt_s, rise_nxt_s, fall_nxt_s, long_nxt_s;

    // Next state and debounce count.
    always_comb begin
        state_nxt_s  = state_r;
        db_cnt_nxt_s = db_cnt_r;
        case (state_r)
            LOW: begin
                if (dbif.s_in) begin
                    if (DB_SINGLE) begin
                        state_nxt_s  = HIGH;
                        db_cnt_nxt_s = DB_ZERO;
                    end else begin
                        state_nxt_s  = ARM_HIGH;
                        db_cnt_nxt_s = DB_ONE;
                    end
                end else begin
                    state_nxt_s  = LOW;
                    db_cnt_nxt_s = DB_ZERO;
                end
            end
            ARM_HIGH: begin
                if (!dbif.s_in) begin
                    state_nxt_s  = LOW;
                    db_cnt_nxt_s = DB_ZERO;
                end else if (db_cnt_r == DB_LAST) begin
                    state_nxt_s  = HIGH;
                    db_cnt_nxt_s = DB_ZERO;
                end else begin
                    state_nxt_s  = ARM_HIGH;
                    db_cnt_nxt_s = db_cnt_r + DB_ONE;
                end
            end
            HIGH: begin
                if (!dbif.s_in) begin
                    if (DB_SINGLE) begin
                        state_nxt_s  = LOW;
                        db_cnt_nxt_s = DB_ZERO;
                    end else begin
                        state_nxt_s  = ARM_LOW;
                        db_cnt_nxt_s = DB_ONE;
                    end
                end else begin
                    state_nxt_s  = HIGH;
                    db_cnt_nxt_s = DB_ZERO;
                end
            end
            ARM_LOW: begin
                if (dbif.s_in) begin
                    state_nxt_s  = HIGH;
                    db_cnt_nxt_s = DB_ZERO;
                end else if (db_cnt_r == DB_LAST) begin
                    state_nxt_s  = LOW;
                    db_cnt_nxt_s = DB_ZERO;
                end else begin
                    state_nxt_s  = ARM_LOW;
                    db_cnt_nxt_s = db_cnt_r + DB_ONE;
                end
            end
            default: begin
                state_nxt_s  = LOW;
                db_cnt_nxt_s = DB_ZERO;
            end
        endcase
    end

    // Output pulses and hold counter; a return from ARM_LOW to HIGH is not a new press.
    always_comb begin
        clean_nxt_s    = (state_nxt_s == HIGH) || (state_nxt_s == ARM_LOW);
        rise_nxt_s     = (state_nxt_s == HIGH) && ((state_r == LOW) || (state_r == ARM_HIGH));
        fall_nxt_s     = (state_nxt_s == LOW) && ((state_r == HIGH) || (state_r == ARM_LOW));
        hold_cnt_nxt_s = hold_cnt_r;
        if (rise_nxt_s) begin
            hold_cnt_nxt_s = HOLD_ZERO;
        end else if ((state_r == HIGH) && (hold_cnt_r != HOLD_MAX)) begin
            hold_cnt_nxt_s = hold_cnt_r + HOLD_ONE;
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end
        // Saturation makes this fire once per press; a coincident fall wins.
        long_nxt_s = (state_r == HIGH) && (hold_cnt_r == HOLD_LAST) && !fall_nxt_s;
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_r    <= LOW;
            db_cnt_r   <= DB_ZERO;
            hold_cnt_r <= HOLD_ZERO;
            clean_r    <= 1'b0;
            rise_r     <= 1'b0;
            fall_r     <= 1'b0;
            long_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            db_cnt_r   <= db_cnt_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            clean_r    <= clean_nxt_s;
            rise_r     <= rise_nxt_s;
            fall_r     <= fall_nxt_s;
            long_r     <= long_nxt_s;
        end
    end

    assign dbif.clean_out = clean_r;
    assign dbif.rise_out  = rise_r;
    assign dbif.fall_out  = fall_r;
    assign dbif.long_out  = long_r;

endmodule

// File: tb/tb_debouncer.sv
// Directed scoreboard bench for debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_debouncer;

    logic clk_in;
    logic rst_n_in;
    int   checks;
    int   errors;
    logic [3:0] exp_q[$];

    debouncer_if dbif ();

    debouncer #(
        .DEBOUNCE_CYCLES (32'd4),
        .LONG_CYCLES     (32'd10)
    ) dut (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .dbif     (dbif)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // One clock: drive s_in, queue the expected {clean,rise,fall,long}, then compare after the edge.
    task automatic cyc(input logic s, input logic [3:0] exp, input string tag);
        logic [3:0] obs;
        logic [3:0] want;
        dbif.s_in = s;
        exp_q.push_back(exp);
        @(posedge clk_in);
        #1;
        want = exp_q.pop_front();
        obs  = {dbif.clean_out, dbif.rise_out, dbif.fall_out, dbif.long_out};
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    task automatic run(input logic s, input int n, input logic [3:0] exp, input string tag);
        for (int i = 0; i < n; i++) begin
            cyc(s, exp, tag);
        end
    endtask

    task automatic pulse_reset(input logic s, input string tag);
        rst_n_in = 1'b0;
        cyc(s, 4'b0000, tag);
        rst_n_in = 1'b1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n_in  = 1'b0;
        dbif.s_in = 1'b0;

        pulse_reset(1'b0, "reset_idle");
        run(1'b0, 2, 4'b0000, "idle");

        // Full press: rise on the 4th sampled high, long 10 cycles later, once only.
        run(1'b1, 3, 4'b0000, "arm_high");
        cyc(1'b1, 4'b1100, "rise");
        run(1'b1, 9, 4'b1000, "hold");
        cyc(1'b1, 4'b1001, "long");
        run(1'b1, 10, 4'b1000, "no_second_long");
        run(1'b0, 3, 4'b1000, "arm_low");
        cyc(1'b0, 4'b0010, "fall");
        run(1'b0, 2, 4'b0000, "low_after_fall");

        // Short high burst is filtered.
        run(1'b1, 3, 4'b0000, "short_high");
        run(1'b0, 3, 4'b0000, "short_high_gone");

        // Low glitch while high delays long by two cycles.
        run(1'b1, 3, 4'b0000, "arm_high2");
        cyc(1'b1, 4'b1100, "rise2");
        run(1'b1, 6, 4'b1000, "hold2");
        run(1'b0, 2, 4'b1000, "glitch_low");
        run(1'b1, 3, 4'b1000, "hold2_resume");
        cyc(1'b1, 4'b1001, "long_delayed");
        run(1'b1, 2, 4'b1000, "after_long2");
        run(1'b0, 3, 4'b1000, "arm_low2");
        cyc(1'b0, 4'b0010, "fall2");
        run(1'b0, 2, 4'b0000, "low_after_fall2");

        // Short press: fall without long.
        run(1'b1, 3, 4'b0000, "arm_high3");
        cyc(1'b1, 4'b1100, "rise3");
        run(1'b1, 5, 4'b1000, "hold3");
        run(1'b0, 3, 4'b1000, "release3");
        cyc(1'b0, 4'b0010, "fall3");
        run(1'b0, 3, 4'b0000, "no_long3");

        // Reset mid-debounce, then debounce normally with input held high.
        run(1'b1, 2, 4'b0000, "arm_before_reset");
        pulse_reset(1'b1, "reset_arm_high");
        run(1'b1, 3, 4'b0000, "rearm");
        cyc(1'b1, 4'b1100, "rise_after_reset");
        run(1'b1, 2, 4'b1000, "hold4");

        // Reset while high: outputs drop with no fall pulse.
        pulse_reset(1'b0, "reset_high");
        run(1'b0, 3, 4'b0000, "no_fall_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
